// File: rtl/instruc_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, word geometry
// and the end-of-program marker.
package instruc_loader_pkg;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instruc_loader.sv
// Assembles UART bytes MSB-first into 32-bit words and writes them to
// consecutive instruction-memory addresses until HALT or memory full.
module instruc_loader
  import instruc_loader_pkg::*;
#(
  parameter int BITS_SIZE  = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int SIZE_TOTAL = 256
) (
  input  logic                                              i_clk,
  input  logic                                              i_reset,
  input  logic                                              i_load_start,
  input  logic [BYTE_SIZE-1:0]                              i_rx_data,
  input  logic                                              i_rx_done,
  output logic [BITS_SIZE-1:0]                              o_instruction_address,
  output logic [BITS_SIZE-1:0]                              o_instruction,
  output logic                                              o_flag_write_intruc,
  output logic                                              o_busy,
  output logic                                              o_load_done,
  output logic                                              o_full,
  output logic [$clog2(SIZE_TOTAL/BYTES_PER_WORD):0]        o_word_count
);

  localparam int                   WC_W      = $clog2(SIZE_TOTAL/BYTES_PER_WORD) + 1;
  localparam logic [BITS_SIZE-1:0] LAST_ADDR = BITS_SIZE'(SIZE_TOTAL - BYTES_PER_WORD);
  localparam logic [BITS_SIZE-1:0] ADDR_STEP = BITS_SIZE'(BYTES_PER_WORD);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [BITS_SIZE-1:0] word_q, word_d;
  logic [BITS_SIZE-1:0] addr_q, addr_d;
  logic [BITS_SIZE-1:0] instr_q, instr_d;
  logic [BITS_SIZE-1:0] iaddr_q, iaddr_d;
  logic [WC_W-1:0]      wc_q, wc_d;
  logic                 full_q, full_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BITS_SIZE-1:0] shifted_s;

  // Next-state and datapath: the full check precedes any address increment.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    iaddr_d   = iaddr_q;
    wc_d      = wc_q;
    full_d    = full_q;
    strobe_d  = 1'b0;
    shifted_s = {word_q[BITS_SIZE-BYTE_SIZE-1:0], i_rx_data};

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_load_start) begin
          state_d = ST_RECV;
          cnt_d   = 2'd0;
          addr_d  = '0;
          wc_d    = '0;
          full_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RECV: begin
        if (i_rx_done) begin
          word_d = shifted_s;
          if (cnt_q == 2'd3) begin
            state_d  = ST_WRITE;
            cnt_d    = 2'd0;
            strobe_d = 1'b1;
            instr_d  = shifted_s;
            iaddr_d  = addr_q;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WRITE: begin
        wc_d = wc_q + WC_W'(1);
        // A byte arriving in the write cycle starts the next word.
        if (i_rx_done) begin
          word_d = shifted_s;
          cnt_d  = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
        if (instr_q == BITS_SIZE'(HALT_WORD)) begin
          state_d = ST_DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          full_d  = 1'b1;
        end else begin
          state_d = ST_RECV;
          addr_d  = addr_q + ADDR_STEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any load with no partial write.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      word_q   <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
      iaddr_q  <= '0;
      wc_q     <= '0;
      full_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      iaddr_q  <= iaddr_d;
      wc_q     <= wc_d;
      full_q   <= full_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_instruction_address = iaddr_q;
  assign o_instruction         = instr_q;
  assign o_flag_write_intruc   = strobe_q;
  assign o_busy                = busy_q;
  assign o_load_done           = done_q;
  assign o_full                = full_q;
  assign o_word_count          = wc_q;

endmodule

// File: tb/tb_instruc_loader.sv
// Randomized bench for instruc_loader: a word-level reference model predicts
// every output each cycle; literal expectations pin the key scenarios.
module tb_instruc_loader;
  import instruc_loader_pkg::*;

  localparam int NWORDS = 64;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_load_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_done = 1'b0;
  logic [31:0] o_instruction_address;
  logic [31:0] o_instruction;
  logic        o_flag_write_intruc;
  logic        o_busy;
  logic        o_load_done;
  logic        o_full;
  logic [6:0]  o_word_count;

  instruc_loader dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_load_start          (i_load_start),
    .i_rx_data             (i_rx_data),
    .i_rx_done             (i_rx_done),
    .o_instruction_address (o_instruction_address),
    .o_instruction         (o_instruction),
    .o_flag_write_intruc   (o_flag_write_intruc),
    .o_busy                (o_busy),
    .o_load_done           (o_load_done),
    .o_full                (o_full),
    .o_word_count          (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is a sequence of bytes grouped in fours; the
  // k-th written word goes to address 4*k, ending on HALT or after 64 words.
  bit          m_loading, m_strobe, m_done, m_full;
  int          m_count, m_nbytes;
  logic [31:0] m_word, m_instr, m_iaddr;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_loading = 0; m_strobe = 0; m_done = 0; m_full = 0;
      m_count = 0; m_nbytes = 0; m_word = '0; m_instr = '0; m_iaddr = '0;
    end else if (m_strobe) begin
      m_strobe = 0;
      m_count++;
      if (m_instr == 32'hFFFF_FFFF || m_count == NWORDS) begin
        m_loading = 0;
        m_done    = 1;
        m_full    = (m_instr != 32'hFFFF_FFFF);
        m_nbytes  = 0;
      end else if (i_rx_done) begin
        m_word   = {24'h0, i_rx_data};
        m_nbytes = 1;
      end else begin
        m_nbytes = 0;
      end
    end else if (m_loading) begin
      if (i_rx_done) begin
        m_word = (m_word << 8) | {24'h0, i_rx_data};
        m_nbytes++;
        if (m_nbytes == 4) begin
          m_strobe = 1;
          m_instr  = m_word;
          m_iaddr  = 32'(4 * m_count);
          m_nbytes = 0;
        end
      end
    end else if (i_load_start) begin
      m_loading = 1; m_done = 0; m_full = 0; m_count = 0; m_nbytes = 0;
    end
  end

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  // Per-cycle compare against the model, plus a log of observed writes.
  always begin
    @(negedge i_clk);
    #1;
    check("strobe", 32'(o_flag_write_intruc), 32'(m_strobe));
    check("busy", 32'(o_busy), 32'(m_loading));
    check("load_done", 32'(o_load_done), 32'(m_done));
    check("full", 32'(o_full), 32'(m_full));
    check("word_count", 32'(o_word_count), 32'(m_count));
    check("instruction", o_instruction, m_instr);
    check("address", o_instruction_address, m_iaddr);
    if (o_flag_write_intruc) begin
      log_addr.push_back(o_instruction_address);
      log_data.push_back(o_instruction);
    end
  end

  task automatic drive_cycle(input bit start, input bit rxd, input logic [7:0] data);
    @(negedge i_clk);
    i_load_start = start;
    i_rx_done    = rxd;
    i_rx_data    = data;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    drive_cycle(0, 1, b);
    idle($urandom_range(0, gap_max));
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap_max);
  endtask

  task automatic start_load();
    drive_cycle(1, 0, 8'h00);
    drive_cycle(0, 0, 8'h00);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && !o_load_done; k++) @(negedge i_clk);
    #2;
    check("done_timeout", 32'(o_load_done), 32'd1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h0;
    return w;
  endfunction

  int          base;
  logic [31:0] wa, wb, wc;

  initial begin
    #1 i_reset = 1'b0;
    // Bytes during reset must not produce writes.
    send_word(32'h2001_0005, 0);
    #2;
    check("reset_no_write", 32'(log_data.size()), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_wc", 32'(o_word_count), 32'd0);
    @(negedge i_clk) i_reset = 1'b1;
    // Bytes without a start are ignored.
    send_word(32'h1122_3344, 1);
    idle(2);
    check("idle_no_write", 32'(log_data.size()), 32'd0);

    // Basic load.
    start_load();
    send_word(32'h2001_0005, 1);
    send_word(32'hFFFF_FFFF, 1);
    wait_done(50);
    check("basic_n", 32'(log_data.size()), 32'd2);
    if (log_data.size() >= 2) begin
      check("basic_d0", log_data[0], 32'h2001_0005);
      check("basic_a0", log_addr[0], 32'h0);
      check("basic_d1", log_data[1], 32'hFFFF_FFFF);
      check("basic_a1", log_addr[1], 32'h4);
    end
    check("basic_wc", 32'(o_word_count), 32'd2);
    check("basic_full", 32'(o_full), 32'd0);
    check("model_wc", 32'(m_count), 32'd2);

    // Fill memory with non-HALT words.
    base = log_data.size();
    start_load();
    for (int k = 0; k < NWORDS; k++) send_word(rand_word(), 2);
    wait_done(50);
    check("full_n", 32'(log_data.size() - base), 32'd64);
    check("full_last_addr", log_addr[log_addr.size()-1], 32'd252);
    check("full_flag", 32'(o_full), 32'd1);
    check("full_wc", 32'(o_word_count), 32'd64);
    base = log_data.size();
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h0102_0304, 0);
    idle(3);
    check("full_extra", 32'(log_data.size() - base), 32'd0);
    check("full_still_done", 32'(o_load_done), 32'd1);

    // Back-to-back bytes, including one in each write cycle.
    base = log_data.size();
    wa = rand_word(); wb = rand_word(); wc = rand_word();
    start_load();
    send_word(wa, 0); send_word(wb, 0); send_word(wc, 0); send_word(32'hFFFF_FFFF, 0);
    wait_done(20);
    check("b2b_n", 32'(log_data.size() - base), 32'd4);
    if (log_data.size() - base >= 4) begin
      check("b2b_d0", log_data[base], wa);
      check("b2b_d1", log_data[base+1], wb);
      check("b2b_d2", log_data[base+2], wc);
      check("b2b_a3", log_addr[base+3], 32'd12);
    end

    // Abort mid-word by reset, then a clean load from address 0.
    base = log_data.size();
    start_load();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    @(negedge i_clk) i_reset = 1'b0;
    idle(2);
    check("abort_no_write", 32'(log_data.size() - base), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk) i_reset = 1'b1;
    start_load();
    send_word(32'h1234_5678, 1);
    send_word(32'hFFFF_FFFF, 1);
    wait_done(30);
    if (log_data.size() - base >= 1) begin
      check("abort_d0", log_data[base], 32'h1234_5678);
      check("abort_a0", log_addr[base], 32'h0);
    end else begin
      check("abort_n", 32'(log_data.size() - base), 32'd2);
    end

    // Start pulses while busy are ignored.
    base = log_data.size();
    start_load();
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    drive_cycle(1, 0, 8'h00);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    drive_cycle(1, 1, 8'h05);
    send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 1);
    send_word(32'hFFFF_FFFF, 0);
    wait_done(30);
    check("busy_start_n", 32'(log_data.size() - base), 32'd3);
    if (log_data.size() - base >= 3) begin
      check("busy_start_d0", log_data[base], 32'h0102_0304);
      check("busy_start_d1", log_data[base+1], 32'h0506_0708);
      check("busy_start_a1", log_addr[base+1], 32'h4);
      check("busy_start_a2", log_addr[base+2], 32'h8);
    end

    // Randomized traffic with stray starts and occasional HALT words.
    for (int ld = 0; ld < 6; ld++) begin
      start_load();
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 5) == 0) wa = 32'hFFFF_FFFF;
        else wa = $urandom;
        for (int b = 3; b >= 0; b--) begin
          drive_cycle($urandom_range(0, 9) == 0, 1, wa[8*b +: 8]);
          idle($urandom_range(0, 2));
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge i_clk) i_reset = 1'b0;
        @(negedge i_clk) i_reset = 1'b1;
      end
      idle(3);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
